// File: rtl/tqvp_prism_timer_bank.sv
// tqvp_prism_timer_bank: moded counter/timer bank with W1C interrupt status and a masked output latch
module tqvp_prism_timer_bank #(
  parameter int NUM_CNT = 2,
  parameter int CNT_W   = 16,
  parameter int LATCH_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         address,
  input  logic [31:0]        data_in,
  input  logic [1:0]         data_write_n,
  input  logic [1:0]         data_read_n,
  output logic [31:0]        data_out,
  output logic               data_ready,
  input  logic               halt,
  input  logic [NUM_CNT-1:0] cnt_run,
  input  logic [NUM_CNT-1:0] cnt_load,
  input  logic [LATCH_W-1:0] fsm_out,
  input  logic               latch_strobe,
  output logic [LATCH_W-1:0] pin_out,
  output logic [NUM_CNT-1:0] cnt_flag,
  output logic               user_interrupt
);
  localparam logic [8:0] INT_M = 9'h100 | 9'((1 << NUM_CNT) - 1);
  logic [CNT_W-1:0]   cnt_q [NUM_CNT];
  logic [CNT_W-1:0]   cnt_d [NUM_CNT];
  logic [CNT_W-1:0]   reload_q [NUM_CNT];
  logic [CNT_W-1:0]   reload_d [NUM_CNT];
  logic [2:0]         cfg_q [NUM_CNT];
  logic [2:0]         cfg_d [NUM_CNT];
  logic [LATCH_W-1:0] mask_q, mask_d, latch_q, latch_d;
  logic [8:0]         st_q, st_d, en_q, en_d;
  logic               halt_q;
  logic [NUM_CNT-1:0] ev;
  logic               wr;
  logic               unused_ok;
  assign wr = data_write_n == 2'b10;
  assign data_ready = 1'b1;
  assign user_interrupt = |(st_q & en_q);
  assign pin_out = (mask_q & latch_q) | (~mask_q & fsm_out);
  assign unused_ok = &{1'b0, data_read_n, data_in};
  always_comb begin
    mask_d = (wr && address == 6'h00) ? data_in[LATCH_W-1:0] : mask_q;
    latch_d = (latch_strobe && !halt) ? fsm_out : latch_q;
    en_d = (wr && address == 6'h08) ? data_in[8:0] & INT_M : en_q;
    data_out = address == 6'h00 ? 32'(mask_q) | (32'(latch_q) << 8)
             : address == 6'h04 ? 32'(st_q)
             : address == 6'h08 ? 32'(en_q) : '0;
    ev = '0;
    cnt_flag = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      logic [1:0] m;
      logic z, hit;
      m = cfg_q[i][1:0];
      z = cnt_q[i] == '0;
      hit = cnt_q[i] == reload_q[i];
      cnt_d[i] = (halt || m == 2'b00) ? cnt_q[i]
               : cnt_load[i] ? (m == 2'b11 ? '0 : reload_q[i])
               : !cnt_run[i] ? cnt_q[i]
               : m == 2'b11 ? ((cfg_q[i][2] && hit) ? '0 : cnt_q[i] + CNT_W'(1))
               : z ? (m == 2'b10 ? reload_q[i] : cnt_q[i])
               : cnt_q[i] - CNT_W'(1);
      // load or halt never raises an event; only a run-driven transition does
      ev[i] = !halt && !cnt_load[i] && cnt_run[i] &&
              (m == 2'b11 ? (cnt_d[i] == reload_q[i] && !hit) : (m != 2'b00 && cnt_q[i] == CNT_W'(1)));
      cnt_flag[i] = m == 2'b11 ? hit : (m != 2'b00 && z);
      reload_d[i] = (wr && address == 6'(16 + 8 * i)) ? data_in[CNT_W-1:0] : reload_q[i];
      cfg_d[i] = (wr && address == 6'(20 + 8 * i)) ? data_in[2:0] : cfg_q[i];
      if (address == 6'(16 + 8 * i)) data_out = 32'(reload_q[i]);
      if (address == 6'(20 + 8 * i)) data_out = (32'(cnt_q[i]) << 8) | 32'(cfg_q[i]);
    end
    st_d = (st_q & ~((wr && address == 6'h04) ? data_in[8:0] : 9'h0)) | {halt && !halt_q, 8'(ev)};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q <= '0;
      latch_q <= '0;
      st_q <= '0;
      en_q <= '0;
      halt_q <= 1'b0;
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= '0;
        reload_q[i] <= '0;
        cfg_q[i] <= '0;
      end
    end else begin
      mask_q <= mask_d;
      latch_q <= latch_d;
      st_q <= st_d;
      en_q <= en_d;
      halt_q <= halt;
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= cnt_d[i];
        reload_q[i] <= reload_d[i];
        cfg_q[i] <= cfg_d[i];
      end
    end
  end
endmodule
